// File: rtl/vga_timing_rx_if.sv
// vga_timing_rx_if: video input stream plus recovered pixel and timing outputs
interface vga_timing_rx_if;
    logic        vga_hs, vga_vs, vga_en;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        pix_valid, sof, eol, locked;
    logic [10:0] pix_x, pix_y, h_total, h_active, v_total, v_active;
    logic [23:0] pix_rgb;
    logic [2:0]  mode;
    modport master (
        output vga_hs, vga_vs, vga_en, vga_r, vga_g, vga_b,
        input  pix_valid, sof, eol, locked, pix_x, pix_y, pix_rgb,
        input  h_total, h_active, v_total, v_active, mode
    );
    modport slave (
        input  vga_hs, vga_vs, vga_en, vga_r, vga_g, vga_b,
        output pix_valid, sof, eol, locked, pix_x, pix_y, pix_rgb,
        output h_total, h_active, v_total, v_active, mode
    );
endinterface

// File: rtl/vga_timing_rx.sv
// vga_timing_rx: VGA receiver recovering pixel coordinates, timing measurements and lock
module vga_timing_rx #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic vga_clk,
    input  logic rst_n,
    vga_timing_rx_if.slave bus
);
    typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;
    state_t      state, state_nxt;
    logic        hs1, vs1, en1, hs1_d, vs1_d, en1_d;
    logic        hs_fall, vs_fall, en_fall, same, timeout;
    logic [23:0] rgb1;
    logic [10:0] line_cnt, en_cnt, hs_cnt, de_cnt, y_nxt;
    logic [11:0] idle_cnt;
    logic [43:0] meas, snap, dims;
    logic [7:0]  match_cnt;

    function automatic logic [10:0] inc(input logic [10:0] v);
        return v == 11'h7ff ? v : v + 11'd1;
    endfunction

    assign hs_fall = hs1_d & ~hs1;
    assign vs_fall = vs1_d & ~vs1;
    assign en_fall = en1_d & ~en1;
    assign y_nxt   = vs_fall ? 11'd0 : en_fall ? inc(bus.pix_y) : bus.pix_y;
    // v counts are compared before they land in v_total/v_active
    assign meas    = {bus.h_total, bus.h_active, hs_cnt, de_cnt};
    assign dims    = {bus.h_total, bus.h_active, bus.v_total, bus.v_active};
    assign same    = meas == snap;
    assign timeout = idle_cnt == 12'hfff || (hs_fall && !vs_fall && hs_cnt == 11'h7ff);

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            {hs1, vs1, en1, hs1_d, vs1_d, en1_d} <= 6'b110110;
            rgb1 <= '0;
        end else begin
            {hs1, vs1, en1} <= {bus.vga_hs, bus.vga_vs, bus.vga_en};
            {hs1_d, vs1_d, en1_d} <= {hs1, vs1, en1};
            rgb1 <= {bus.vga_r, bus.vga_g, bus.vga_b};
        end
    end

    // eol looks one pixel ahead at the raw enable to flag the last pixel in time
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            {bus.pix_valid, bus.sof, bus.eol} <= '0;
            bus.pix_x   <= '0;
            bus.pix_y   <= '0;
            bus.pix_rgb <= '0;
        end else begin
            bus.pix_valid <= en1;
            bus.pix_rgb   <= rgb1;
            bus.pix_x     <= (en1 && en1_d) ? inc(bus.pix_x) : 11'd0;
            bus.pix_y     <= y_nxt;
            bus.sof       <= en1 && !en1_d && y_nxt == 11'd0;
            bus.eol       <= en1 && !bus.vga_en;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            {line_cnt, en_cnt, hs_cnt, de_cnt} <= '0;
            idle_cnt <= '0;
            {bus.h_total, bus.h_active, bus.v_total, bus.v_active} <= '0;
        end else begin
            line_cnt     <= hs_fall ? 11'd1 : inc(line_cnt);
            idle_cnt     <= hs_fall ? 12'd0 : idle_cnt == 12'hfff ? idle_cnt : idle_cnt + 12'd1;
            en_cnt       <= en_fall ? 11'd0 : en1 ? inc(en_cnt) : en_cnt;
            bus.h_total  <= hs_fall ? line_cnt : bus.h_total;
            bus.h_active <= en_fall ? en_cnt : bus.h_active;
            bus.v_total  <= vs_fall ? hs_cnt : bus.v_total;
            bus.v_active <= vs_fall ? de_cnt : bus.v_active;
            hs_cnt <= vs_fall ? {10'd0, hs_fall} : hs_fall ? inc(hs_cnt) : hs_cnt;
            de_cnt <= vs_fall ? {10'd0, en_fall} : en_fall ? inc(de_cnt) : de_cnt;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) state <= UNLOCKED;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = timeout ? UNLOCKED : !vs_fall ? state :
                    (state == UNLOCKED || !same) ? CHECK :
                    (state == LOCKED || int'(match_cnt) + 1 >= LOCK_FRAMES - 1) ? LOCKED : CHECK;
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            snap      <= '0;
            match_cnt <= '0;
        end else if (vs_fall && !timeout) begin
            snap      <= (state == UNLOCKED || !same) ? meas : snap;
            match_cnt <= (state == UNLOCKED || !same) ? 8'd0 :
                         state == CHECK ? match_cnt + 8'd1 : match_cnt;
        end
    end

    always_comb begin
        bus.locked = state == LOCKED;
        bus.mode   = state != LOCKED ? 3'd0 :
                     dims == {11'd800, 11'd640, 11'd525, 11'd480} ? 3'd1 :
                     dims == {11'd1056, 11'd800, 11'd628, 11'd600} ? 3'd2 :
                     dims == {11'd1344, 11'd1024, 11'd806, 11'd768} ? 3'd3 :
                     dims == {11'd1688, 11'd1280, 11'd1066, 11'd1024} ? 3'd4 : 3'd7;
    end
endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: directed frames on two reduced timings with a per-cycle pixel model
module tb_vga_timing_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    bit pix_chk = 1'b0;
    logic p_en = 1'b0, p_eol = 1'b0;
    logic [10:0] p_x = '0, p_y = '0;
    logic [23:0] p_rgb = '0;
    logic lk0, lk1;
    logic [10:0] ht0;
    // timing 0: 40x12 lines, 20x7 active; timing 1: 48x14 lines, 32x8 active
    localparam int HT[2]  = '{40, 48};
    localparam int HSW[2] = '{4, 5};
    localparam int HDS[2] = '{10, 12};
    localparam int HDE[2] = '{29, 43};
    localparam int VT[2]  = '{12, 14};
    localparam int VSW[2] = '{2, 3};
    localparam int VDS[2] = '{3, 4};
    localparam int VDE[2] = '{9, 11};

    vga_timing_rx_if ifc();
    vga_timing_rx #(.LOCK_FRAMES(2)) dut (.vga_clk(clk), .rst_n(rst_n), .bus(ifc));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return 128'({ifc.pix_valid, ifc.sof, ifc.eol, ifc.pix_x, ifc.pix_y, ifc.pix_rgb,
                     ifc.h_total, ifc.h_active, ifc.v_total, ifc.v_active, ifc.locked, ifc.mode});
    endfunction

    function automatic logic [127:0] meas();
        return 128'({ifc.h_total, ifc.h_active, ifc.v_total, ifc.v_active});
    endfunction

    task automatic tick(input logic hs, input logic vs, input logic en, input logic [10:0] x,
                        input logic [10:0] y, input logic [23:0] rgb, input logic last);
        ifc.vga_hs = hs;
        ifc.vga_vs = vs;
        ifc.vga_en = en;
        {ifc.vga_r, ifc.vga_g, ifc.vga_b} = rgb;
        @(posedge clk);
        #1;
        if (pix_chk)
            check("pix",
                  128'({ifc.pix_valid, ifc.sof, ifc.eol, ifc.pix_x, p_en ? ifc.pix_y : 11'd0, ifc.pix_rgb}),
                  128'({p_en, p_en && p_x == 11'd0 && p_y == 11'd0, p_en && p_eol,
                        p_en ? p_x : 11'd0, p_en ? p_y : 11'd0, p_rgb}));
        {p_en, p_eol, p_x, p_y, p_rgb} = {en, last, x, y, rgb};
    endtask

    task automatic frame(input int t, input int l0);
        for (int l = l0; l < VT[t]; l++)
            for (int c = 0; c < HT[t]; c++) begin
                tick(c >= HSW[t], l >= VSW[t],
                     l >= VDS[t] && l <= VDE[t] && c >= HDS[t] && c <= HDE[t],
                     11'(c - HDS[t]), 11'(l - VDS[t]),
                     {c[7:0], l[7:0], 8'ha5 ^ c[7:0]}, c == HDE[t]);
                if (l == 0 && c == 0) lk0 = ifc.locked;
                if (l == 0 && c == 1) lk1 = ifc.locked;
                if (l == 0 && c == 2) ht0 = ifc.h_total;
            end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 24'h0, 1'b0);
    endtask

    initial begin
        {ifc.vga_hs, ifc.vga_vs, ifc.vga_en} = 3'b001;
        {ifc.vga_r, ifc.vga_g, ifc.vga_b} = 24'hffffff;
        repeat (3) @(posedge clk);
        #1;
        check("rst_all", outs(), 128'd0);
        {ifc.vga_hs, ifc.vga_vs, ifc.vga_en} = 3'b110;
        {ifc.vga_r, ifc.vga_g, ifc.vga_b} = 24'h0;
        #2 rst_n = 1'b1;
        pix_chk = 1'b1;
        frame(0, 0);
        check("a1_h", 128'({ifc.locked, ifc.h_total, ifc.h_active}), 128'({1'b0, 11'd40, 11'd20}));
        frame(0, 0);
        check("a2_meas", meas(), 128'({11'd40, 11'd20, 11'd12, 11'd7}));
        check("a2_lock", 128'({lk0, lk1}), 128'(2'b00));
        frame(0, 0);
        check("a3_lock_edge", 128'({lk0, lk1}), 128'(2'b01));
        check("a3_mode", 128'({ifc.locked, ifc.mode}), 128'(4'b1111));
        frame(1, 0);
        check("b1_lock", 128'({lk0, lk1}), 128'(2'b11));
        frame(1, 0);
        check("b2_unlock", 128'({lk0, lk1}), 128'(2'b10));
        check("b2_meas", meas(), 128'({11'd48, 11'd32, 11'd14, 11'd8}));
        frame(1, 0);
        check("b3_relock", 128'({lk0, lk1}), 128'(2'b01));
        check("b3_mode", 128'({ifc.locked, ifc.mode}), 128'(4'b1111));
        idle(3900);
        check("idle_pre", 128'({ifc.locked, ifc.mode}), 128'(4'b1111));
        idle(300);
        check("idle_to", 128'({ifc.locked, ifc.mode}), 128'(4'b0000));
        idle(800);
        frame(0, 0);
        check("ht_sat", 128'(ht0), 128'(11'd2047));
        frame(0, 0);
        frame(0, 0);
        check("relock", 128'({lk0, lk1}), 128'(2'b01));
        pix_chk = 1'b0;
        fork
            frame(0, 0);
            begin
                repeat (220) @(posedge clk);
                #2 check("pre_rst", 128'({ifc.locked, ifc.pix_valid}), 128'(2'b11));
                #1 rst_n = 1'b0;
                #1 check("rst_mid", outs(), 128'd0);
                repeat (3) @(posedge clk);
                #3 rst_n = 1'b1;
            end
        join
        pix_chk = 1'b1;
        frame(0, 0);
        check("rst_x", 128'({lk0, lk1}), 128'(2'b00));
        frame(0, 0);
        check("rst_y", 128'({lk0, lk1}), 128'(2'b00));
        frame(0, 0);
        check("rst_relock", 128'({lk0, lk1}), 128'(2'b01));
        check("rst_meas", meas(), 128'({11'd40, 11'd20, 11'd12, 11'd7}));
        for (int k = 0; k < 2100; k++) begin
            for (int c = 0; c < 6; c++)
                tick(c >= 1, 1'b1, 1'b0, 11'd0, 11'd0, {8'(c), 8'(k), 8'h3c}, 1'b0);
            if (k == 2019) check("hs_pre", 128'({ifc.locked, ifc.h_total}), 128'({1'b1, 11'd6}));
            if (k == 2059) check("hs_to", 128'({ifc.locked, ifc.mode}), 128'(4'b0000));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_rx.md
VGA_TIMING_RX -- requirements
Module: vga_timing_rx

Interface
REQ-001 SHALL have parameter: LOCK_FRAMES, 2, consecutive identical frame measurements required to assert locked.
REQ-002 SHALL have port: vga_clk  in  1  pixel clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port: vga_hs  in  1  horizontal sync, active-low pulse.
REQ-006 SHALL have port: vga_vs  in  1  vertical sync, active-low pulse.
REQ-007 SHALL have port: vga_en  in  1  data enable, high during active pixels.
REQ-008 SHALL have port: vga_r / vga_g / vga_b  in  8 each  pixel colour.
REQ-009 SHALL have port: pix_valid  out  1  active pixel strobe.
REQ-010 SHALL have port: pix_x / pix_y  out  11 each  active-pixel coordinates, 0-based.
REQ-011 SHALL have port: pix_rgb  out  24  {r,g,b} of the current pixel.
REQ-012 SHALL have port: sof  out  1  first active pixel of a frame.
REQ-013 SHALL have port: eol  out  1  last active pixel of a line.
REQ-014 SHALL have port: h_total / h_active / v_total / v_active  out  11 each  latched measurements.
REQ-015 SHALL have port: locked  out  1  timing stable.
REQ-016 SHALL have port: mode  out  3  detected resolution code.

Function
REQ-017 SHALL register all inputs once (stage 1); all edge detection SHALL use stage-1 values against their previous-cycle copies.
REQ-018 SHALL produce pixel outputs at stage 2: an input sampled at edge n appears on pix_* at edge n+2, so latency = 2 cycles.
REQ-019 SHALL assert pix_valid = stage-1 vga_en delayed one cycle, and pix_rgb SHALL carry the matching colour.
REQ-020 pix_x SHALL be 0 on the first pixel after vga_en rises, increment per valid pixel, saturate at 2047, and reset to 0 while vga_en is low.
REQ-021 pix_y SHALL reset to 0 on a vga_vs falling edge and increment by 1 on each vga_en falling edge, saturating at 2047.
REQ-022 sof SHALL pulse for 1 cycle with the pixel where pix_x=0 and pix_y=0; eol SHALL pulse with the last pixel before vga_en falls.
REQ-023 A line counter SHALL count clocks between vga_hs falling edges; on each hs fall it SHALL latch into h_total (clocks per line) and restart at 1; it SHALL saturate at 2047.
REQ-024 h_active SHALL latch the vga_en-high clock count of a line at each vga_en falling edge.
REQ-025 v_total SHALL latch the hs-fall count since the previous vs fall, at each vs fall.
REQ-026 v_active SHALL latch the vga_en falling-edge count since the previous vs fall, at each vs fall.
REQ-027 When hs and vs fall in the same cycle, v_total/v_active SHALL latch the old-frame counts, and that hs fall SHALL count as line 1 of the new frame.
REQ-028 Lock state machine: states UNLOCKED, CHECK, LOCKED.
REQ-029 UNLOCKED->CHECK SHALL occur at the first vs fall, which snapshots the four measurements.
REQ-030 In CHECK, each vs fall SHALL compare against the snapshot; a match increments the match count, and when the count reaches LOCK_FRAMES-1 the state SHALL go to LOCKED.
REQ-031 In CHECK, a mismatch SHALL re-snapshot and clear the match count.
REQ-032 In LOCKED, any mismatch at a vs fall SHALL go to CHECK with a re-snapshot and locked deasserted.
REQ-033 Timeout: 4096 clocks without an hs fall, or 2048 hs falls without a vs fall, SHALL force UNLOCKED.
REQ-034 locked SHALL be high only in LOCKED and SHALL update on the cycle after the deciding vs fall.
REQ-035 mode SHALL be 0 when not locked; when locked it SHALL be decoded from the measurements (h_total,h_active,v_total,v_active): (800,640,525,480)=1, (1056,800,628,600)=2, (1344,1024,806,768)=3, (1688,1280,1066,1024)=4, other=7.

Reset
REQ-036 On rst_n low, all outputs, counters and measurements SHALL be 0, the state machine SHALL be UNLOCKED, and input stage registers SHALL be hs=1, vs=1, en=0.
REQ-037 On rst_n low mid-frame, the block SHALL drop to reset values immediately; after release, the first vs fall SHALL be treated as the first frame seen.

Verification
REQ-038 Drive 1024x768 timing (line 1344, hs 136, de 296..1319, frame 806 lines, vs 6, de lines 35..802) for 3 frames -> h_total=1344, h_active=1024, v_total=806, v_active=768; locked=1 after the 2nd vs fall; mode=3.
REQ-039 With the same stream, check the pixel path -> sof with pix_x=0/pix_y=0 two cycles after the first de-high input; eol at pix_x=1023; last line pix_y=767; pix_rgb equals the input delayed 2 cycles.
REQ-040 Switch to 800x600 (1056/628) while locked -> locked=0 at the first mismatching vs fall; relock after 2 matching frames; mode=2.
REQ-041 Hold vga_hs high for 5000 clocks -> locked=0 and mode=0 by clock 4096.
REQ-042 Assert rst_n=0 at mid-line 400 -> all outputs 0 within the same cycle; after release, locked=1 after two full frames.
REQ-043 Drive hs and vs falling in the same cycle -> v_total=806 (not 807) and the next frame counts that line as 1.
